// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// Builds a W = 4*NIBBLES bit add/subtract from an external 4-bit ripple-carry
// adder. The operands are latched on start and fed to the adder one nibble per
// cycle, least significant nibble first. Each sum slice and carry-out is
// captured, and the carry is chained into the next nibble. The full result,
// carry and signed overflow are registered when the last slice completes.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_s,
  input  logic                   add_cout,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   ovf
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Extract nibble i of a W-bit vector.
  function automatic logic [3:0] nib(input logic [W-1:0] v, input logic [IDX_W-1:0] i);
    logic [W-1:0] sh;
    sh  = v >> {i, 2'b00};
    nib = sh[3:0];
  endfunction

  state_t           state_r, state_s;

  logic [W-1:0]     a_r, a_s;
  logic [W-1:0]     b_r, b_s;        // already inverted for subtract
  logic             carry_r, carry_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [W-1:0]     sum_r, sum_s;

  logic [W-1:0]     result_r, result_s;
  logic             cout_r, cout_s;
  logic             ovf_r, ovf_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [3:0]       add_a_r, add_a_s;
  logic [3:0]       add_b_r, add_b_s;
  logic             add_cin_r, add_cin_s;

  logic [W-1:0]     b_eff_s;
  logic [IDX_W-1:0] idx_inc_s;

  assign b_eff_s   = sub ? ~op_b : op_b;
  assign idx_inc_s = idx_r + IDX_ONE;

  // State register with synchronous reset that overrides start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN for NIBBLES cycles, one DONE cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (idx_r == LAST_IDX) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Output/datapath logic: computes next values of every registered output
  // and of the operand, carry, index and sum registers. The adder-facing
  // outputs are precomputed for the coming cycle, so they stay registered
  // while still presenting nibble idx during each RUN cycle.
  always_comb begin
    a_s       = a_r;
    b_s       = b_r;
    carry_s   = carry_r;
    idx_s     = idx_r;
    sum_s     = sum_r;
    result_s  = result_r;
    cout_s    = cout_r;
    ovf_s     = ovf_r;
    busy_s    = 1'b0;
    done_s    = 1'b0;
    add_a_s   = 4'h0;
    add_b_s   = 4'h0;
    add_cin_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          a_s       = op_a;
          b_s       = b_eff_s;
          carry_s   = sub;
          idx_s     = IDX_ZERO;
          busy_s    = 1'b1;
          add_a_s   = op_a[3:0];
          add_b_s   = b_eff_s[3:0];
          add_cin_s = sub;
        end else begin
          busy_s    = 1'b0;
          add_cin_s = 1'b0;
        end
      end
      ST_RUN: begin
        sum_s[{idx_r, 2'b00} +: 4] = add_s;
        carry_s = add_cout;
        if (idx_r == LAST_IDX) begin
          // Final slice: publish the assembled result and flags.
          idx_s    = IDX_ZERO;
          result_s = sum_s;
          cout_s   = add_cout;
          ovf_s    = (a_r[W-1] == b_r[W-1]) && (add_s[3] != a_r[W-1]);
          busy_s   = 1'b0;
          done_s   = 1'b1;
        end else begin
          idx_s     = idx_inc_s;
          busy_s    = 1'b1;
          add_a_s   = nib(a_r, idx_inc_s);
          add_b_s   = nib(b_r, idx_inc_s);
          add_cin_s = add_cout;
        end
      end
      ST_DONE: begin
        done_s = 1'b0;
        busy_s = 1'b0;
      end
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset clears everything, aborting any run.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= {W{1'b0}};
      b_r       <= {W{1'b0}};
      carry_r   <= 1'b0;
      idx_r     <= IDX_ZERO;
      sum_r     <= {W{1'b0}};
      result_r  <= {W{1'b0}};
      cout_r    <= 1'b0;
      ovf_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      add_a_r   <= 4'h0;
      add_b_r   <= 4'h0;
      add_cin_r <= 1'b0;
    end else begin
      a_r       <= a_s;
      b_r       <= b_s;
      carry_r   <= carry_s;
      idx_r     <= idx_s;
      sum_r     <= sum_s;
      result_r  <= result_s;
      cout_r    <= cout_s;
      ovf_r     <= ovf_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      add_a_r   <= add_a_s;
      add_b_r   <= add_b_s;
      add_cin_r <= add_cin_s;
    end
  end

  assign add_a   = add_a_r;
  assign add_b   = add_b_r;
  assign add_cin = add_cin_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign result  = result_r;
  assign cout    = cout_r;
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Testbench for nibble_serial_add_ctrl (NIBBLES=4). Provides a behavioural
// 4-bit adder and checks every operation against a wide-arithmetic model.
module tb_nibble_serial_add_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_s;
  logic         add_cout;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int total;
  int bad;

  nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .op_a     (op_a),
    .op_b     (op_b),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .ovf      (ovf)
  );

  // External 4-bit adder.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete operation, checking every RUN cycle and the DONE cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] beff;
    logic [W-1:0] er;
    logic         ec;
    logic         eo;
    logic [W-1:0] prev_res;
    int sa, sb, r, mask, c;
    beff = s ? ~b : b;
    er   = s ? (a - b) : (a + b);
    ec   = s ? (a >= b) : ((32'(a) + 32'(b)) > 32'h0000FFFF);
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    r    = s ? (sa - sb) : (sa + sb);
    eo   = (r > 32767) || (r < -32768);
    @(negedge clk);
    start = 1'b1; sub = s; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; sub = 1'($urandom); op_a = 16'($urandom); op_b = 16'($urandom);
    for (int i = 0; i < N; i++) begin
      if (i > 0) @(negedge clk);
      mask = (1 << (4 * i)) - 1;
      c = ((int'(a) & mask) + (int'(beff) & mask) + int'(s)) >> (4 * i);
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_done", 32'(done), 32'd0);
      chk("add_a", 32'(add_a), (32'(a) >> (4 * i)) & 32'hF);
      chk("add_b", 32'(add_b), (32'(beff) >> (4 * i)) & 32'hF);
      chk("add_cin", 32'(add_cin), 32'(c));
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("result", 32'(result), 32'(er));
    chk("cout", 32'(cout), 32'(ec));
    chk("ovf", 32'(ovf), 32'(eo));
    chk("done_add_a", 32'({add_a, add_b, add_cin}), 32'd0);
    prev_res = result;
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_hold", 32'(result), 32'(er));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b1;
    sub   = 1'b0;
    op_a  = 16'h1111;
    op_b  = 16'h2222;
    repeat (2) @(negedge clk);
    // Reset state (start held high must be overridden).
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'({cout, ovf}), 32'd0);
    chk("rst_add", 32'({add_a, add_b, add_cin}), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy0", 32'(busy), 32'd0);

    // Directed cases.
    run_op(16'h1234, 16'h0FCD, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b1);
    run_op(16'h0000, 16'h8000, 1'b1);
    run_op(16'h1234, 16'h1234, 1'b1);

    // Random cases.
    for (int k = 0; k < 24; k++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom));
    end

    // start held high: one operation every 6 cycles.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; op_a = 16'h0001; op_b = 16'h0001;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      chk("hold_busy", 32'(busy), ((n % 6) >= 1 && (n % 6) <= 4) ? 32'd1 : 32'd0);
      chk("hold_done", 32'(done), ((n % 6) == 5) ? 32'd1 : 32'd0);
      chk("hold_excl", 32'(busy & done), 32'd0);
      if ((n % 6) == 5) begin
        chk("hold_result", 32'(result), 32'h0002);
      end else begin
        chk("hold_cin_idle", 32'((n % 6) == 0 ? add_cin : 1'b0), 32'd0);
      end
      if (n == 18) start = 1'b0;
    end

    // Reset in the second RUN cycle aborts the operation.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; op_a = 16'h1234; op_b = 16'h0FCD;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_flags", 32'({cout, ovf}), 32'd0);
    chk("abort_add", 32'({add_a, add_b, add_cin}), 32'd0);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_no_busy", 32'(busy), 32'd0);
    end
    run_op(16'h0003, 16'h0004, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
